// File: rtl/id_probe.sv
// Probes the fixed extension ID register over a req/ack read port and reports
// match, mismatch or timeout; timed-out reads are retried a bounded number of times.
module id_probe #(
  parameter logic [7:0]        EXP_ID  = 8'hA5,
  parameter int                ADDR_W  = 8,
  parameter logic [ADDR_W-1:0] ID_ADDR = '0,
  parameter int                TIMEOUT = 16,
  parameter int                RETRIES = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [7:0]        rd_data,
  output logic              busy,
  output logic              done,
  output logic              id_ok,
  output logic              id_err,
  output logic              timeout_err,
  output logic [7:0]        id_value
);

  localparam int TW = $clog2(TIMEOUT);
  localparam int AW = $clog2(RETRIES + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    GAP   = 2'd2,
    CHECK = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     timer_q, timer_d;
  logic [AW-1:0]     attempt_q, attempt_d;
  logic [AW-1:0]     attempt_inc;
  logic              rd_req_q, rd_req_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              id_ok_q, id_ok_d;
  logic              id_err_q, id_err_d;
  logic              timeout_err_q, timeout_err_d;
  logic [7:0]        id_value_q, id_value_d;

  assign attempt_inc = attempt_q + AW'(1);

  always_comb begin
    state_d       = state_q;
    timer_d       = timer_q;
    attempt_d     = attempt_q;
    rd_req_d      = rd_req_q;
    busy_d        = busy_q;
    done_d        = 1'b0;
    id_ok_d       = id_ok_q;
    id_err_d      = id_err_q;
    timeout_err_d = timeout_err_q;
    id_value_d    = id_value_q;

    case (state_q)
      IDLE: begin
        busy_d   = 1'b0;
        rd_req_d = 1'b0;
        if (start) begin
          state_d       = WAIT;
          id_ok_d       = 1'b0;
          id_err_d      = 1'b0;
          timeout_err_d = 1'b0;
          attempt_d     = '0;
          timer_d       = '0;
          rd_req_d      = 1'b1;
          busy_d        = 1'b1;
        end
      end
      WAIT: begin
        // An ack takes priority over the expiring timer on the same cycle.
        if (rd_ack) begin
          id_value_d = rd_data;
          rd_req_d   = 1'b0;
          state_d    = CHECK;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          rd_req_d  = 1'b0;
          attempt_d = attempt_inc;
          if (attempt_inc < AW'(RETRIES)) begin
            state_d = GAP;
          end else begin
            state_d       = IDLE;
            timeout_err_d = 1'b1;
            done_d        = 1'b1;
            busy_d        = 1'b0;
          end
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      GAP: begin
        state_d  = WAIT;
        timer_d  = '0;
        rd_req_d = 1'b1;
      end
      CHECK: begin
        if (id_value_q == EXP_ID) begin
          id_ok_d = 1'b1;
        end else begin
          id_err_d = 1'b1;
        end
        done_d  = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        state_d  = IDLE;
        rd_req_d = 1'b0;
        busy_d   = 1'b0;
      end
    endcase

    rd_addr_d = rd_req_d ? ID_ADDR : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      timer_q       <= '0;
      attempt_q     <= '0;
      rd_req_q      <= 1'b0;
      rd_addr_q     <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      id_ok_q       <= 1'b0;
      id_err_q      <= 1'b0;
      timeout_err_q <= 1'b0;
      id_value_q    <= 8'h00;
    end else begin
      state_q       <= state_d;
      timer_q       <= timer_d;
      attempt_q     <= attempt_d;
      rd_req_q      <= rd_req_d;
      rd_addr_q     <= rd_addr_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      id_ok_q       <= id_ok_d;
      id_err_q      <= id_err_d;
      timeout_err_q <= timeout_err_d;
      id_value_q    <= id_value_d;
    end
  end

  assign rd_req      = rd_req_q;
  assign rd_addr     = rd_addr_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign id_ok       = id_ok_q;
  assign id_err      = id_err_q;
  assign timeout_err = timeout_err_q;
  assign id_value    = id_value_q;

endmodule

// File: doc/id_probe.md
Name: id_probe

Overview:
- Reader-side companion to the fixed 8-bit extension ID register (ID value 8'hA5).
- On a start pulse it issues a read of the ID register over a simple req/ack read port. It captures the returned byte and compares it with the expected ID.
- It reports match, mismatch or timeout, so the DLX side or bring-up logic can confirm the sharpening extension is present before using it.
- Timed-out reads are retried a bounded number of times.

Parameters:
- EXP_ID, 8'hA5, expected ID byte.
- ADDR_W, 8, read address width.
- ID_ADDR, 0, address of the ID register on the read port.
- TIMEOUT, 16, cycles to wait for rd_ack per attempt (>=2).
- RETRIES, 3, total attempts before declaring timeout (>=1).

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to probe; ignored while busy.
- rd_req  out  1  read request, held high until ack or timeout.
- rd_addr  out  ADDR_W  driven to ID_ADDR whenever rd_req=1, else 0.
- rd_ack  in  1  responder accepts and returns data this cycle.
- rd_data  in  8  ID byte, valid when rd_ack=1.
- busy  out  1  probe in progress.
- done  out  1  one-cycle completion pulse.
- id_ok  out  1  last probe matched EXP_ID (sticky until next start).
- id_err  out  1  last probe returned a wrong value (sticky).
- timeout_err  out  1  all attempts timed out (sticky).
- id_value  out  8  byte captured on last rd_ack.

Behaviour:
- All outputs are registered. Reset (async, any time, including mid-read) forces state IDLE and all outputs to 0 immediately, with rd_req and rd_addr low. id_value resets to 8'h00.
- FSM states:
  - IDLE: busy=0. start=1 -> WAIT. On that edge, clear id_ok/id_err/timeout_err, set attempt=0, timer=0, rd_req=1, busy=1.
  - WAIT: rd_req=1, rd_addr=ID_ADDR.
    - rd_ack=1 sampled -> id_value<=rd_data, rd_req<=0, go to CHECK. Ack wins even on the cycle timer==TIMEOUT-1.
    - No ack and timer==TIMEOUT-1 -> rd_req<=0, attempt<=attempt+1. If attempt+1<RETRIES go to GAP, else go to IDLE with timeout_err<=1, done<=1, busy<=0.
    - Otherwise timer<=timer+1.
  - GAP: one cycle with rd_req=0, then WAIT with timer=0 and rd_req=1. This guarantees at least one low cycle between attempts.
  - CHECK: compare id_value with EXP_ID. Match -> id_ok<=1, else id_err<=1. In both cases done<=1, busy<=0, go to IDLE.
- done is high for exactly one cycle, then drops to 0.
- Latency: start sampled at edge k gives rd_req high from k. Ack sampled at edge m gives done and flags visible after edge m+1.
- start while busy=1: ignored, no restart.
- start on the same edge that done is asserted: accepted, and flags clear on that edge.
- rd_ack while rd_req=0 (IDLE/GAP/CHECK): ignored, id_value unchanged.
- Mismatch is not retried; only timeouts retry.
- Exactly one of id_ok/id_err/timeout_err is set after each completed probe.
- Timer width is clog2(TIMEOUT). Attempt counter width is clog2(RETRIES+1).

Test Plan:
- Reset, then start; responder acks on the 3rd cycle with rd_data=8'hA5. Required: rd_addr=0 while rd_req is high; rd_req drops after ack; 1-cycle done; id_ok=1, id_value=8'hA5.
- Start; responder returns 8'h5A. Required: id_err=1, id_ok=0, id_value=8'h5A, done pulses once, no second rd_req.
- No ack at all. Required: 3 rd_req windows of 16 cycles each, separated by 1 low cycle; then timeout_err=1 with done, total 50 cycles from start to done.
- First attempt times out; second attempt acks 8'hA5 on cycle 16 of its window (timer==15). Required: ack wins, id_ok=1, timeout_err=0.
- Assert reset mid-WAIT (rd_req=1). Required: rd_req, busy and flags go to 0 asynchronously, before the next edge. A later start restarts cleanly.
- Pulse start again while busy, and apply a stray rd_ack in IDLE. Required: no restart, id_value unchanged, flags unchanged.
